// File: rtl/uart_msg_sequencer.sv
// Feeds a fixed ASCII message, one byte per frame, into async_transmitter
// through its start/busy handshake; one message per trigger pulse.
module uart_msg_sequencer #(
  parameter int                   MSG_LEN     = 8,
  parameter logic [8*MSG_LEN-1:0] MSG         = "Hello!..",
  parameter int                   GAP_CYCLES  = 0,
  parameter int                   ACK_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [4:0] char_idx
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_ACK,
    WAIT_DONE,
    GAP
  } state_t;

  localparam logic [4:0]  LAST_IDX = 5'(MSG_LEN - 1);
  localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t      state;
  logic        pending;
  logic [15:0] cnt;

  // Full 32-entry table so the 5-bit index selects without width tricks.
  logic [7:0] chars [32];

  for (genvar g = 0; g < 32; g++) begin : g_chars
    if (g < MSG_LEN) begin : g_used
      assign chars[g] = MSG[8*(MSG_LEN-g)-1 -: 8];
    end else begin : g_pad
      assign chars[g] = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      char_idx <= 5'd0;
      pending  <= 1'b0;
      cnt      <= 16'd0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      if (state != IDLE && trigger)
        pending <= 1'b1;
      unique case (state)
        IDLE: begin
          if (trigger || pending) begin
            state    <= LOAD;
            busy     <= 1'b1;
            char_idx <= 5'd0;
            pending  <= 1'b0;
          end
        end
        LOAD: begin
          tx_data <= chars[char_idx];
          if (!tx_busy) begin
            state    <= START;
            tx_start <= 1'b1;
          end
        end
        START: begin
          state <= WAIT_ACK;
          cnt   <= 16'd0;
        end
        WAIT_ACK: begin
          if (tx_busy)
            state <= WAIT_DONE;
          else if (cnt == ACK_LAST)
            state <= LOAD;
          else
            cnt <= cnt + 16'd1;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (char_idx == LAST_IDX) begin
              state    <= IDLE;
              done     <= 1'b1;
              busy     <= 1'b0;
              char_idx <= 5'd0;
            end else begin
              char_idx <= char_idx + 5'd1;
              cnt      <= 16'd0;
              state    <= (GAP_CYCLES > 0) ? GAP : LOAD;
            end
          end
        end
        GAP: begin
          if (cnt == GAP_LAST)
            state <= LOAD;
          else
            cnt <= cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Self-checking bench: table scenarios plus timing corner cases,
// with a byte scoreboard fed at trigger time and drained on tx_start.
module tb_uart_msg_sequencer;

  logic       clk;
  logic       rst;
  logic       trig0, trig1;
  logic       tx_busy0, tx_busy1;
  logic       tx_start0, tx_start1;
  logic [7:0] tx_data0, tx_data1;
  logic       busy0, busy1;
  logic       done0, done1;
  logic [4:0] idx0, idx1;

  uart_msg_sequencer #(
    .MSG_LEN(8), .MSG("Hello!.."),
    .GAP_CYCLES(0), .ACK_TIMEOUT(4)
  ) dut0 (
    .clk(clk), .rst(rst), .trigger(trig0),
    .tx_busy(tx_busy0), .tx_start(tx_start0),
    .tx_data(tx_data0), .busy(busy0),
    .done(done0), .char_idx(idx0)
  );

  uart_msg_sequencer #(
    .MSG_LEN(8), .MSG("Hello!.."),
    .GAP_CYCLES(3), .ACK_TIMEOUT(4)
  ) dut1 (
    .clk(clk), .rst(rst), .trigger(trig1),
    .tx_busy(tx_busy1), .tx_start(tx_start1),
    .tx_data(tx_data1), .busy(busy1),
    .done(done1), .char_idx(idx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter models: busy rises 1 cycle after start, high 10 cycles.
  // Model 0 can ignore one chosen start; neither is cleared by rst.
  int bcnt0 = 0;
  int sc0   = 0;
  int ign0  = -1;
  int bcnt1 = 0;

  always @(posedge clk) begin
    if (rst) sc0 <= 0;
    else if (tx_start0) sc0 <= sc0 + 1;
    if (tx_start0 && !rst && sc0 != ign0) bcnt0 <= 10;
    else if (bcnt0 != 0) bcnt0 <= bcnt0 - 1;
  end

  always @(posedge clk) begin
    if (tx_start1 && !rst) bcnt1 <= 10;
    else if (bcnt1 != 0) bcnt1 <= bcnt1 - 1;
  end

  assign tx_busy0 = (bcnt0 != 0);
  assign tx_busy1 = (bcnt1 != 0);

  typedef struct {
    int n_trig;
    int spacing;
    int ign;
    int exp_starts;
    int exp_dones;
  } scen_t;

  scen_t      tbl [4];
  logic [7:0] msg [8];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int npass = 0;
  int ntot  = 0;
  int starts0 = 0, dones0 = 0;
  int starts1 = 0, dones1 = 0;

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_msg(input int inst);
    for (int i = 0; i < 8; i++) begin
      if (inst == 0) q0.push_back(msg[i]);
      else q1.push_back(msg[i]);
    end
  endtask

  task automatic wait_done0(input int d0, input int want);
    int n;
    n = 0;
    while (dones0 - d0 < want && n < 3000) begin
      tick();
      n++;
    end
    chk("done0_timeout", int'(n < 3000), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  initial begin
    int s0, d0, n, d;
    rst   = 1'b1;
    trig0 = 1'b0;
    trig1 = 1'b0;
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C,
            8'h6F, 8'h21, 8'h2E, 8'h2E};
    tbl[0] = '{1, 1, -1, 8, 1};
    tbl[1] = '{4, 15, -1, 16, 2};
    tbl[2] = '{1, 1, 0, 9, 1};
    tbl[3] = '{2, 50, 3, 17, 2};

    fork
      forever begin
        @(negedge clk);
        if (tx_start0) begin
          starts0++;
          chk("start0_while_busy", int'(tx_busy0), 0);
          chk("start0_queued", int'(q0.size() > 0), 1);
          if (q0.size() > 0) begin
            if (sc0 == ign0) chk("tx_data0", int'(tx_data0), int'(q0[0]));
            else chk("tx_data0", int'(tx_data0), int'(q0.pop_front()));
          end
        end
        if (done0) dones0++;
        if (tx_start1) begin
          starts1++;
          chk("start1_while_busy", int'(tx_busy1), 0);
          chk("start1_queued", int'(q1.size() > 0), 1);
          if (q1.size() > 0)
            chk("tx_data1", int'(tx_data1), int'(q1.pop_front()));
        end
        if (done1) dones1++;
      end
    join_none

    tick();
    tick();
    chk("rst_tx_start", int'(tx_start0), 0);
    chk("rst_tx_data", int'(tx_data0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_char_idx", int'(idx0), 0);
    rst = 1'b0;
    tick();

    // Table-driven message scenarios on the GAP_CYCLES=0 instance
    for (int i = 0; i < 4; i++) begin
      do_reset();
      ign0 = tbl[i].ign;
      s0 = starts0;
      d0 = dones0;
      for (int t = 0; t < tbl[i].n_trig; t++) begin
        trig0 = 1'b1;
        if (t < 2) push_msg(0);
        tick();
        trig0 = 1'b0;
        if (t != tbl[i].n_trig - 1)
          repeat (tbl[i].spacing - 1) tick();
      end
      wait_done0(d0, tbl[i].exp_dones);
      repeat (30) tick();
      chk("scen_starts", starts0 - s0, tbl[i].exp_starts);
      chk("scen_dones", dones0 - d0, tbl[i].exp_dones);
      chk("scen_busy_end", int'(busy0), 0);
      chk("scen_idx_end", int'(idx0), 0);
      chk("scen_queue_left", q0.size(), 0);
    end
    ign0 = -1;

    // Trigger-to-start latency, then done timing against last busy fall
    do_reset();
    repeat (3) tick();
    s0 = starts0;
    d0 = dones0;
    push_msg(0);
    trig0 = 1'b1;
    tick();
    trig0 = 1'b0;
    chk("lat_n1_start", int'(tx_start0), 0);
    chk("lat_n1_busy", int'(busy0), 1);
    tick();
    chk("lat_n2_start", int'(tx_start0), 1);
    chk("lat_n2_data", int'(tx_data0), 8'h48);
    n = 0;
    while (starts0 - s0 < 8 && n < 2000) begin
      tick();
      n++;
    end
    chk("eighth_start_timeout", int'(n < 2000), 1);
    n = 0;
    while (tx_busy0 && n < 50) begin
      tick();
      n++;
    end
    chk("last_busy_fall_timeout", int'(n < 50), 1);
    chk("done_at_fall", int'(done0), 0);
    tick();
    chk("done_after_fall", int'(done0), 1);
    chk("busy_after_fall", int'(busy0), 0);
    chk("idx_after_fall", int'(idx0), 0);
    tick();
    chk("done_one_cycle", int'(done0), 0);
    chk("done_count", dones0 - d0, 1);

    // Ignored first start: reissue spacing and data
    do_reset();
    ign0 = 0;
    d0 = dones0;
    push_msg(0);
    trig0 = 1'b1;
    tick();
    trig0 = 1'b0;
    n = 0;
    while (!tx_start0 && n < 20) begin
      tick();
      n++;
    end
    chk("ign_first_data", int'(tx_data0), 8'h48);
    tick();
    d = 1;
    while (!tx_start0 && d < 50) begin
      tick();
      d++;
    end
    chk("ign_reissue_dist", d, 6);
    chk("ign_reissue_data", int'(tx_data0), 8'h48);
    wait_done0(d0, 1);
    ign0 = -1;

    // Gap spacing on the GAP_CYCLES=3 instance
    push_msg(1);
    trig1 = 1'b1;
    tick();
    trig1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!tx_start1 && n < 50) begin
        tick();
        n++;
      end
      tick();
      while (tx_busy1 && n < 50) begin
        tick();
        n++;
      end
      chk("gap_wait_timeout", int'(n < 50), 1);
      d = 0;
      while (!tx_start1 && d < 50) begin
        tick();
        d++;
      end
      chk("gap_fall_to_start", d, 5);
    end
    n = 0;
    while (dones1 == 0 && n < 2000) begin
      tick();
      n++;
    end
    chk("gap_done_timeout", int'(n < 2000), 1);
    chk("gap_idx_end", int'(idx1), 0);

    // Reset in WAIT_DONE of char 3
    do_reset();
    s0 = starts0;
    push_msg(0);
    trig0 = 1'b1;
    tick();
    trig0 = 1'b0;
    n = 0;
    while (starts0 - s0 < 4 && n < 500) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk("mid_idx", int'(idx0), 3);
    chk("mid_tx_busy", int'(tx_busy0), 1);
    rst = 1'b1;
    d0 = dones0;
    q0.delete();
    tick();
    rst = 1'b0;
    chk("mr_tx_start", int'(tx_start0), 0);
    chk("mr_busy", int'(busy0), 0);
    chk("mr_idx", int'(idx0), 0);
    chk("mr_tx_data", int'(tx_data0), 0);
    chk("mr_done", int'(done0), 0);
    repeat (3) tick();
    chk("mr_no_done", dones0 - d0, 0);
    push_msg(0);
    trig0 = 1'b1;
    tick();
    trig0 = 1'b0;
    n = 0;
    while (!tx_start0 && n < 50) begin
      tick();
      n++;
    end
    chk("restart_data", int'(tx_data0), 8'h48);
    chk("restart_tx_idle", int'(tx_busy0), 0);
    wait_done0(d0, 1);
    repeat (5) tick();
    chk("restart_queue_left", q0.size(), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
